alu_pipe: RTL and testbench

- Registered, handshaked successor to the combinational 32-bit ALU, parametrised in operand width.
- Opcode 3'b011, currently NOT_USED, becomes an iterative shift-add multiply (low half of the product).
- Adds zero, overflow and illegal flags, plus valid/ready flow control on input and output.
- Sits between the operand-fetch stage and writeback; one operation in flight at a time.

---
 rtl/alu_pipe_pkg.sv | 20 ++
 rtl/alu_mul_iter.sv | 49 ++++
 rtl/alu_pipe.sv | 120 ++++++++++++
 tb/tb_alu_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode and state definitions shared by the alu_pipe files
package alu_pipe_pkg;

  localparam logic [2:0] ALU_AND      = 3'b000;
  localparam logic [2:0] ALU_OR       = 3'b001;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_MUL      = 3'b011;
  localparam logic [2:0] ALU_NOT_USED = ALU_MUL;
  localparam logic [2:0] ALU_ANDN     = 3'b100;
  localparam logic [2:0] ALU_ORN      = 3'b101;
  localparam logic [2:0] ALU_SUB      = 3'b110;
  localparam logic [2:0] ALU_SLT      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  // product already folds in the step taken on this edge, so it is final while done is high
  assign done    = busy && (cnt == LAST);
  assign product = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered, handshaked ALU with iterative multiply and zero/ovf/illegal flags
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  alu_state_e         state;
  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   res;
  logic               add_ovf;
  logic               sub_ovf;
  logic               res_ovf;
  logic               res_ill;

  assign in_ready = ((state == ST_IDLE) && !mul_busy) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (f == ALU_MUL);

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_ill = 1'b0;
    case (f)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  begin res = sum;  res_ovf = add_ovf; end
      ALU_MUL:  res_ill = 1'b1;
      ALU_ANDN: res = a & ~b;
      ALU_ORN:  res = a | ~b;
      ALU_SUB:  begin res = diff; res_ovf = sub_ovf; end
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default:  res = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              y         <= res;
              zero      <= (res == '0);
              ovf       <= res_ovf;
              illegal   <= res_ill;
            end
          end else if ((state == ST_DONE) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            y         <= mul_prod[WIDTH-1:0];
            zero      <= (mul_prod[WIDTH-1:0] == '0);
            ovf       <= |mul_prod[2*WIDTH-1:WIDTH];
            illegal   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe (32-bit, 5-bit, and MUL-disabled instances)
module tb_alu_pipe;

  typedef struct {
    int          id;
    logic [2:0]  f;
    logic [31:0] y;
    bit          zero;
    bit          ovf;
    bit          ill;
    int          lat;
    longint      t_acc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv    = '0;
  logic [2:0]  ordy  = '1;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [2:0]  f     = '0;
  wire  [2:0]  ir, ov, zr, of, il;
  wire  [31:0] y0, y2;
  wire  [4:0]  y5;

  exp_t sbq[$];
  bit [2:0] seen = '0;
  bit rnd_bp = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .f(f),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(y0), .zero(zr[0]), .ovf(of[0]), .illegal(il[0]));

  alu_pipe #(.WIDTH(5), .MUL_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[4:0]), .b(b[4:0]), .f(f),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(y5), .zero(zr[1]), .ovf(of[1]), .illegal(il[1]));

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .f(f),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2), .zero(zr[2]), .ovf(of[2]), .illegal(il[2]));

  function automatic int wid(int k);
    return (k == 1) ? 5 : 32;
  endfunction

  function automatic logic [31:0] yout(int k);
    case (k)
      0:       return y0;
      1:       return {27'd0, y5};
      default: return y2;
    endcase
  endfunction

  // Reference: plain unsigned/signed integer arithmetic on the operand values
  function automatic exp_t model(int k, logic [2:0] op, logic [31:0] va, logic [31:0] vb);
    exp_t e;
    int w = wid(k);
    bit mul_en = (k != 2);
    longint unsigned m    = (64'd1 << w) - 64'd1;
    longint unsigned ua   = {32'd0, va} & m;
    longint unsigned ub   = {32'd0, vb} & m;
    longint unsigned half = 64'd1 << (w - 1);
    longint sa   = (ua >= half) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    longint sb   = (ub >= half) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    longint smax = longint'(half) - 1;
    longint smin = -longint'(half);
    longint s    = 0;
    longint unsigned r = 0;
    bit o = 1'b0;
    bit ill = 1'b0;
    case (op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: begin r = ua + ub; s = sa + sb; o = (s > smax) || (s < smin); end
      3'd3: if (mul_en) begin r = ua * ub; o = ((r >> w) != 0); end
            else begin r = 0; ill = 1'b1; end
      3'd4: r = ua & ~ub;
      3'd5: r = ua | ~ub;
      3'd6: begin r = ua - ub; s = sa - sb; o = (s > smax) || (s < smin); end
      default: r = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    e.id    = k;
    e.f     = op;
    e.y     = 32'(r & m);
    e.zero  = ((r & m) == 0);
    e.ovf   = o;
    e.ill   = ill;
    e.lat   = (op == 3'd3 && mul_en) ? w + 1 : 1;
    e.t_acc = 0;
    return e;
  endfunction

  task automatic chk(bit ok, string name, longint got, longint want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: samples 2 time units after each falling edge, well clear of the rising edge
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        int   hi;
        int   lat;
        exp_t e;
        hi = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (sbq[i].id == k && hi < 0) hi = i;
        if (ov[k]) begin
          if (hi < 0) begin
            chk(1'b0, $sformatf("dut%0d spurious out_valid", k), 1, 0);
          end else begin
            e = sbq[hi];
            if (!seen[k]) begin
              seen[k] = 1'b1;
              lat = int'(($time - 7 - e.t_acc) / 10) + 1;
              chk(lat == e.lat, $sformatf("dut%0d f=%0d latency", k, e.f), lat, e.lat);
            end
            chk(yout(k) == e.y, $sformatf("dut%0d f=%0d y", k, e.f), yout(k), e.y);
            chk(zr[k] == e.zero, $sformatf("dut%0d f=%0d zero", k, e.f), zr[k], e.zero);
            chk(of[k] == e.ovf, $sformatf("dut%0d f=%0d ovf", k, e.f), of[k], e.ovf);
            chk(il[k] == e.ill, $sformatf("dut%0d f=%0d illegal", k, e.f), il[k], e.ill);
            if (!ordy[k]) begin
              chk(ir[k] == 1'b0, $sformatf("dut%0d in_ready under backpressure", k), ir[k], 0);
            end else begin
              sbq.delete(hi);
              seen[k] = 1'b0;
            end
          end
        end else if (seen[k]) begin
          chk(1'b0, $sformatf("dut%0d out_valid dropped before accept", k), 0, 1);
          seen[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk)
    if (rnd_bp) ordy[0] = ($urandom_range(0, 3) != 0);

  // Call on a falling edge; returns on the falling edge after the accept
  task automatic issue(int k, logic [2:0] op, logic [31:0] va, logic [31:0] vb);
    exp_t e;
    int   n;
    a = va; b = vb; f = op; iv[k] = 1'b1; n = 0;
    #1;
    while (!ir[k] && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (ir[k]) begin
      e = model(k, op, va, vb);
      e.t_acc = longint'($time) + 4;
      sbq.push_back(e);
    end else begin
      chk(1'b0, $sformatf("dut%0d accept timeout", k), 0, 1);
    end
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(sbq.size() == 0, "drain pending results", sbq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk(ov == 3'b000, "reset out_valid", ov, 0);
    chk(y0 == 32'd0, "reset y", y0, 0);
    chk(zr == 3'b000, "reset zero", zr, 0);
    chk(of == 3'b000, "reset ovf", of, 0);
    chk(il == 3'b000, "reset illegal", il, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(ir == 3'b111, "in_ready after reset", ir, 7);

    for (int op = 0; op < 8; op++) issue(0, 3'(op), 32'd25, 32'd7);
    issue(0, 3'd6, 32'd7, 32'd25);
    issue(0, 3'd7, 32'd7, 32'd25);
    issue(0, 3'd3, 32'h0001_0000, 32'h0001_0000);
    issue(0, 3'd3, 32'd0, 32'hFFFF_FFFF);
    issue(0, 3'd2, 32'h7FFF_FFFF, 32'd1);
    issue(0, 3'd6, 32'h8000_0000, 32'd1);
    issue(0, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF);
    drain();

    ordy[0] = 1'b0;
    issue(0, 3'd2, 32'd100, 32'd23);
    repeat (5) @(negedge clk);
    ordy[0] = 1'b1;
    issue(0, 3'd6, 32'd5, 32'd9);
    drain();

    issue(0, 3'd3, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk(ov[0] == 1'b0, "async reset out_valid", ov[0], 0);
    chk(y0 == 32'd0, "async reset y", y0, 0);
    chk(ir[0] == 1'b1, "async reset in_ready", ir[0], 1);
    chk(of[0] == 1'b0, "async reset ovf", of[0], 0);
    sbq.delete();
    seen = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 3'd2, 32'd3, 32'd4);
    drain();

    issue(2, 3'd3, 32'd25, 32'd7);
    issue(2, 3'd2, 32'd25, 32'd7);
    issue(2, 3'd3, 32'd0, 32'd0);
    drain();

    issue(1, 3'd3, 32'd7, 32'd3);
    issue(1, 3'd3, 32'd31, 32'd31);
    issue(1, 3'd2, 32'd15, 32'd1);
    issue(1, 3'd7, 32'd16, 32'd15);
    for (int i = 0; i < 30; i++) issue(1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 120; i++) issue(0, 3'($urandom_range(0, 7)), pick(), pick());
    rnd_bp = 1'b0;
    @(negedge clk);
    ordy[0] = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
